// File: rtl/axis_write_addr.sv
`default_nettype none
// ============================================================================
//  Module      : axis_write_addr
//  Description : Write-path command stage. Accepts one write job (start byte
//                address, length in stream words), hands the stream-word
//                length to axis_write_data, then issues AXI AW bursts of at
//                most 2^AXI_LEN_WIDTH beats that never cross a 4 KB boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_write_addr #(
   parameter int CFG_DWIDTH     = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_LEN_WIDTH  = 4,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int CONVERT_SHIFT  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CFG_DWIDTH-1:0]     cfg_address,
   input  logic [CFG_DWIDTH-1:0]     cfg_length,
   input  logic                      cfg_val,
   output logic                      cfg_rdy,
   output logic [CFG_DWIDTH-1:0]     data_length,
   output logic                      data_val,
   input  logic                      data_rdy,
   output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
   output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
   output logic                      axi_awvalid,
   input  logic                      axi_awready,
   output logic                      busy
);

   // log2 of bytes per AXI beat
   localparam int c_byte_shift = $clog2(AXI_DATA_WIDTH / 8);
   // largest burst in beats, widened for comparison against the beat counter
   localparam logic [CFG_DWIDTH-1:0] c_maxb = CFG_DWIDTH'(1) << AXI_LEN_WIDTH;
   // rounding term so a partial group of stream words still costs a full beat
   localparam logic [CFG_DWIDTH:0] c_round = (CFG_DWIDTH+1)'((1 << CONVERT_SHIFT) - 1);
   localparam logic [AXI_LEN_WIDTH:0] c_one = (AXI_LEN_WIDTH+1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CALC = 2'd2,
      ADDR = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [CFG_DWIDTH-1:0]     r_beats;

   logic                      w_accept;
   logic [AXI_ADDR_WIDTH-1:0] w_cfg_addr;
   logic [CFG_DWIDTH:0]       w_beats_sum;
   logic [12:0]               w_room_beats;
   logic [CFG_DWIDTH-1:0]     w_room_ext;
   logic [CFG_DWIDTH-1:0]     w_min_len;
   logic [CFG_DWIDTH-1:0]     w_min_all;
   logic [AXI_LEN_WIDTH:0]    w_blen;
   logic [CFG_DWIDTH-1:0]     w_beats_left;
   logic [AXI_ADDR_WIDTH-1:0] w_addr_step;

   // Job acceptance, beat rounding and burst sizing arithmetic
   always_comb begin
      w_accept     = cfg_val & cfg_rdy;
      w_cfg_addr   = AXI_ADDR_WIDTH'(cfg_address);
      w_beats_sum  = {1'b0, cfg_length} + c_round;
      // beats left before the next 4 KB page; the address is beat-aligned
      w_room_beats = (13'h1000 - {1'b0, r_addr[11:0]}) >> c_byte_shift;
      w_room_ext   = CFG_DWIDTH'(w_room_beats);
      w_min_len    = (r_beats < c_maxb) ? r_beats : c_maxb;
      w_min_all    = (w_room_ext < w_min_len) ? w_room_ext : w_min_len;
      w_blen       = (AXI_LEN_WIDTH+1)'(w_min_all);
      w_beats_left = r_beats - CFG_DWIDTH'(w_blen);
      w_addr_step  = AXI_ADDR_WIDTH'(w_blen) << c_byte_shift;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            // a zero-length job is consumed without any handoff or burst
            if (w_accept && (cfg_length != '0)) begin
               w_state_next = DATA;
            end
         end
         DATA: begin
            if (data_rdy) begin
               w_state_next = CALC;
            end
         end
         CALC: begin
            w_state_next = ADDR;
         end
         ADDR: begin
            if (axi_awready) begin
               w_state_next = (w_beats_left != '0) ? CALC : IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Registered outputs follow the next state; datapath updates per state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_rdy     <= 1'b0;
         data_val    <= 1'b0;
         axi_awvalid <= 1'b0;
         busy        <= 1'b0;
         r_addr      <= '0;
         r_beats     <= '0;
         data_length <= '0;
         axi_awaddr  <= '0;
         axi_awlen   <= '0;
      end else begin
         cfg_rdy     <= (w_state_next == IDLE);
         data_val    <= (w_state_next == DATA);
         axi_awvalid <= (w_state_next == ADDR);
         busy        <= (w_state_next != IDLE);
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr      <= (w_cfg_addr >> c_byte_shift) << c_byte_shift;
                  r_beats     <= CFG_DWIDTH'(w_beats_sum >> CONVERT_SHIFT);
                  data_length <= cfg_length;
               end
            end
            CALC: begin
               axi_awaddr <= r_addr;
               axi_awlen  <= AXI_LEN_WIDTH'(w_blen - c_one);
            end
            ADDR: begin
               if (axi_awready) begin
                  r_addr  <= r_addr + w_addr_step;
                  r_beats <= w_beats_left;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_write_addr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_write_addr
//  Description : Directed self-checking bench for axis_write_addr.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_write_addr;

   logic        clk;
   logic        rst;
   logic [31:0] cfg_address;
   logic [31:0] cfg_length;
   logic        cfg_val;
   logic        cfg_rdy;
   logic [31:0] data_length;
   logic        data_val;
   logic        data_rdy;
   logic [31:0] axi_awaddr;
   logic [3:0]  axi_awlen;
   logic        axi_awvalid;
   logic        axi_awready;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] aw_addr_q[$];
   logic [3:0]  aw_len_q[$];
   logic [31:0] dl_q[$];

   axis_write_addr dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_address (cfg_address),
      .cfg_length  (cfg_length),
      .cfg_val     (cfg_val),
      .cfg_rdy     (cfg_rdy),
      .data_length (data_length),
      .data_val    (data_val),
      .data_rdy    (data_rdy),
      .axi_awaddr  (axi_awaddr),
      .axi_awlen   (axi_awlen),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after posedge, so at negedge both inputs and
   // outputs show what the next posedge will act on.
   always @(negedge clk) begin
      if (rst && axi_awvalid && axi_awready) begin
         aw_addr_q.push_back(axi_awaddr);
         aw_len_q.push_back(axi_awlen);
      end
      if (rst && data_val && data_rdy) begin
         dl_q.push_back(data_length);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      aw_addr_q.delete();
      aw_len_q.delete();
      dl_q.delete();
   endtask

   // Present one job once cfg_rdy is seen; returns one cycle after acceptance
   task automatic run_job(input string tag, input logic [31:0] addr, input logic [31:0] len);
      int n;
      n = 0;
      while (!cfg_rdy && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_rdy_timeout"}, 64'(n >= 200), 64'd0);
      cfg_address = addr;
      cfg_length  = len;
      cfg_val     = 1'b1;
      tick();
      cfg_val     = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(cfg_rdy && !busy) && n < 5000) begin
         tick();
         n++;
      end
      check({tag, "_idle_timeout"}, 64'(n >= 5000), 64'd0);
   endtask

   // Job 1: 0x1000, 8 words -> one burst 0x1000/awlen 3, first awvalid 2 cycles after accept
   task automatic test1(input string tag);
      clear_q();
      run_job(tag, 32'h1000, 32'd8);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      tick();
      check({tag, "_awvalid_early"}, 64'(axi_awvalid), 64'd0);
      tick();
      check({tag, "_awvalid_lat2"}, 64'(axi_awvalid), 64'd1);
      wait_idle(tag);
      check({tag, "_dl_count"}, 64'(dl_q.size()), 64'd1);
      if (dl_q.size() > 0) check({tag, "_dl"}, 64'(dl_q[0]), 64'd8);
      check({tag, "_aw_count"}, 64'(aw_addr_q.size()), 64'd1);
      if (aw_addr_q.size() > 0) begin
         check({tag, "_awaddr"}, 64'(aw_addr_q[0]), 64'h1000);
         check({tag, "_awlen"}, 64'(aw_len_q[0]), 64'd3);
      end
      check({tag, "_cfg_rdy"}, 64'(cfg_rdy), 64'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cfg_rdy"}, 64'(cfg_rdy), 64'd0);
      check({tag, "_data_val"}, 64'(data_val), 64'd0);
      check({tag, "_awvalid"}, 64'(axi_awvalid), 64'd0);
      check({tag, "_awaddr"}, 64'(axi_awaddr), 64'd0);
      check({tag, "_awlen"}, 64'(axi_awlen), 64'd0);
      check({tag, "_data_length"}, 64'(data_length), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int nbad;
      int n;
      rst         = 1'b0;
      cfg_address = '0;
      cfg_length  = '0;
      cfg_val     = 1'b0;
      data_rdy    = 1'b1;
      axi_awready = 1'b1;

      // Reset state
      tick();
      tick();
      check_zero("rst");
      rst = 1'b1;
      tick();
      check("rst_release_cfg_rdy", 64'(cfg_rdy), 64'd1);

      // Test 1: single short burst
      test1("t1");

      // Test 2: 4092 words -> 2046 beats, 127 full bursts plus awlen 13
      clear_q();
      run_job("t2", 32'h0, 32'd4092);
      wait_idle("t2");
      check("t2_dl", 64'(dl_q.size() > 0 ? dl_q[0] : 32'hFFFF_FFFF), 64'd4092);
      check("t2_count", 64'(aw_addr_q.size()), 64'd128);
      nbad = 0;
      for (int i = 0; i < aw_addr_q.size(); i++) begin
         if (aw_addr_q[i] !== 32'(i * 128)) nbad++;
         if (aw_len_q[i] !== ((i == 127) ? 4'd13 : 4'd15)) nbad++;
      end
      check("t2_bad_bursts", 64'(nbad), 64'd0);
      if (aw_addr_q.size() == 128) begin
         check("t2_last_addr", 64'(aw_addr_q[127]), 64'h3F80);
         check("t2_last_len", 64'(aw_len_q[127]), 64'd13);
      end

      // Test 3: 4 KB crossing splits into two 8-beat bursts
      clear_q();
      run_job("t3", 32'h0FC0, 32'd32);
      wait_idle("t3");
      check("t3_count", 64'(aw_addr_q.size()), 64'd2);
      if (aw_addr_q.size() == 2) begin
         check("t3_addr0", 64'(aw_addr_q[0]), 64'h0FC0);
         check("t3_len0", 64'(aw_len_q[0]), 64'd7);
         check("t3_addr1", 64'(aw_addr_q[1]), 64'h1000);
         check("t3_len1", 64'(aw_len_q[1]), 64'd7);
      end

      // Test 4: unaligned address, odd length rounds up
      clear_q();
      run_job("t4", 32'h2004, 32'd9);
      wait_idle("t4");
      check("t4_count", 64'(aw_addr_q.size()), 64'd1);
      if (aw_addr_q.size() == 1) begin
         check("t4_addr", 64'(aw_addr_q[0]), 64'h2000);
         check("t4_len", 64'(aw_len_q[0]), 64'd4);
      end
      check("t4_dl", 64'(dl_q.size() > 0 ? dl_q[0] : 32'hFFFF_FFFF), 64'd9);

      // Test 5: back-pressure on both handshakes, stray cfg_val ignored
      clear_q();
      data_rdy    = 1'b0;
      axi_awready = 1'b0;
      run_job("t5", 32'h3000, 32'd8);
      nbad = 0;
      for (int i = 0; i < 5; i++) begin
         if (data_val !== 1'b1 || data_length !== 32'd8 || cfg_rdy !== 1'b0) nbad++;
         cfg_val     = (i == 2);
         cfg_address = 32'h5000;
         cfg_length  = 32'd2;
         tick();
      end
      cfg_val = 1'b0;
      check("t5_data_hold", 64'(nbad), 64'd0);
      data_rdy = 1'b1;
      n = 0;
      while (!axi_awvalid && n < 20) begin
         tick();
         n++;
      end
      check("t5_aw_timeout", 64'(n >= 20), 64'd0);
      nbad = 0;
      for (int i = 0; i < 10; i++) begin
         if (axi_awvalid !== 1'b1 || axi_awaddr !== 32'h3000 || axi_awlen !== 4'd3 ||
             cfg_rdy !== 1'b0) nbad++;
         cfg_val = (i == 4);
         tick();
      end
      cfg_val = 1'b0;
      check("t5_aw_hold", 64'(nbad), 64'd0);
      axi_awready = 1'b1;
      wait_idle("t5");
      check("t5_aw_count", 64'(aw_addr_q.size()), 64'd1);
      check("t5_dl_count", 64'(dl_q.size()), 64'd1);

      // Test 6: zero-length job produces nothing
      clear_q();
      run_job("t6", 32'h4000, 32'd0);
      nbad = 0;
      for (int i = 0; i < 6; i++) begin
         if (cfg_rdy !== 1'b1 || busy !== 1'b0 || data_val !== 1'b0 || axi_awvalid !== 1'b0) nbad++;
         tick();
      end
      check("t6_idle_hold", 64'(nbad), 64'd0);
      check("t6_no_traffic", 64'(aw_addr_q.size() + dl_q.size()), 64'd0);

      // Test 7: reset during burst 3 of the long job
      clear_q();
      run_job("t7", 32'h0, 32'd4092);
      n = 0;
      while (!(aw_addr_q.size() == 2 && axi_awvalid) && n < 100) begin
         tick();
         n++;
      end
      check("t7_burst3_timeout", 64'(n >= 100), 64'd0);
      check("t7_pre_awaddr", 64'(axi_awaddr), 64'h100);
      rst = 1'b0;
      #1;
      check_zero("t7_rst");
      tick();
      tick();
      rst = 1'b1;
      tick();
      test1("t7_after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
